// File: rtl/irq_pending_latch_if.sv
// -----------------------------------------------------------------------------
// irq_pending_latch_if
//
// Bundles the request-side and consumer-side signals of irq_pending_latch so
// the block and its environment connect through a single port.
//
// Signals
//   req_in    [7:0]  raw request lines, bit 7 highest priority
//   mask      [7:0]  per-line enable; 0 = held pending but not presented
//   irq_ack          consumer acknowledge of the presented request
//   lost_clr         clears the sticky overrun flags
//   pend_out  [7:0]  pending & mask, the priority encoder's input
//   irq_valid        a request is presented on irq_id
//   irq_id    [2:0]  index of the presented line
//   lost      [7:0]  sticky per-line overrun flags
//
// Modports
//   master  environment side: drives requests, mask, ack and lost_clr
//   slave   irq_pending_latch side: drives pend_out, irq_valid, irq_id, lost
// -----------------------------------------------------------------------------
`default_nettype none

interface irq_pending_latch_if;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       irq_ack;
    logic       lost_clr;
    logic [7:0] pend_out;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic [7:0] lost;

    modport master (
        output req_in,
        output mask,
        output irq_ack,
        output lost_clr,
        input  pend_out,
        input  irq_valid,
        input  irq_id,
        input  lost
    );

    modport slave (
        input  req_in,
        input  mask,
        input  irq_ack,
        input  lost_clr,
        output pend_out,
        output irq_valid,
        output irq_id,
        output lost
    );
endinterface

`default_nettype wire

// File: rtl/irq_pending_latch.sv
// -----------------------------------------------------------------------------
// irq_pending_latch
//
// Request-capture stage in front of the 8-to-3 priority encoder. Requests on
// eight lines are captured (on a rising edge or on level) into pending bits.
// The masked pending vector is exported as the encoder input, and the block
// itself presents the highest-priority pending line through a valid/ack
// handshake, clearing each line once its ack is accepted.
//
// Parameters
//   EDGE_MODE  1 = capture on rising edge of req_in, overruns tracked in lost
//              0 = level capture, lost stays zero
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset; clears every register at once
//   bus   irq_pending_latch_if.slave
//           req_in, mask, irq_ack, lost_clr  (inputs)
//           pend_out, irq_valid, irq_id, lost (outputs)
// -----------------------------------------------------------------------------
`default_nettype none

module irq_pending_latch #(
    parameter bit EDGE_MODE = 1'b1
) (
    input  wire                        clk,
    input  wire                        rst,
    irq_pending_latch_if.slave         bus
);

    // -------------------------------------------------------------------------
    // Handshake states. Kept as plain constants so the encoding matches the
    // existing register maps that expose the state for debug.
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;

    logic [7:0] req_q;       // previous sample of req_in
    logic [7:0] pending;     // captured, not yet serviced requests
    logic [7:0] lost_q;      // sticky overrun flags
    logic [2:0] irq_id_q;    // line currently (or most recently) presented

    logic [7:0] edge_vec;    // new requests seen this cycle
    logic [7:0] pend_out_c;  // pending bits eligible for presentation
    logic [2:0] sel_idx;     // highest set bit of pend_out_c
    logic       ack_accept;  // ack arriving while a request is presented
    logic [7:0] clr_vec;     // one-hot clear of the serviced line
    logic [7:0] ovr_vec;     // overruns detected this cycle

    // -------------------------------------------------------------------------
    // Request detection. In edge mode only a 0->1 transition counts; since
    // req_q resets to zero, a line already high at reset release is seen as a
    // rising edge on the first sampling clock.
    // -------------------------------------------------------------------------
    generate
        if (EDGE_MODE) begin : g_edge
            assign edge_vec = bus.req_in & ~req_q;
        end else begin : g_level
            assign edge_vec = bus.req_in;
        end
    endgenerate

    assign pend_out_c = pending & bus.mask;

    // -------------------------------------------------------------------------
    // Priority select: scanning upward lets the last hit, the highest set
    // bit, win.
    // -------------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend_out_c[i]) begin
                sel_idx = 3'(i);
            end
        end
    end

    // An ack only counts while the request is actually presented; in IDLE or
    // GAP it neither clears a bit nor moves the state machine.
    assign ack_accept = (state == ST_ISSUE) && bus.irq_ack;
    assign clr_vec    = ack_accept ? (8'h01 << irq_id_q) : 8'h00;

    // An overrun is a fresh edge on a line that is still pending and is not
    // being serviced this very cycle. A line cleared and re-requested in the
    // same cycle simply stays pending, which is not a loss.
    generate
        if (EDGE_MODE) begin : g_ovr
            assign ovr_vec = edge_vec & pending & ~clr_vec;
        end else begin : g_no_ovr
            assign ovr_vec = 8'h00;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic for the valid/ack handshake.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pend_out_c != 8'h00) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ack_accept) begin
                    state_nxt = ST_GAP;
                end
            end
            // One idle cycle after service so pend_out reflects the clear
            // before the next selection is made.
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            req_q    <= 8'h00;
            pending  <= 8'h00;
            lost_q   <= 8'h00;
            irq_id_q <= 3'd0;
        end else begin
            state   <= state_nxt;
            req_q   <= bus.req_in;

            // Set is applied after clear so a request arriving on the line
            // being serviced survives.
            pending <= (pending & ~clr_vec) | edge_vec;

            // Overrun is applied after lost_clr so a loss in the clearing
            // cycle is not dropped.
            lost_q  <= (bus.lost_clr ? 8'h00 : lost_q) | ovr_vec;

            // irq_id is captured only when leaving IDLE and then held, so
            // mask changes and later higher-priority requests cannot alter
            // the request already presented.
            if (state == ST_IDLE && pend_out_c != 8'h00) begin
                irq_id_q <= sel_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. irq_valid decodes the state register directly, so it drops
    // together with the asynchronous reset.
    // -------------------------------------------------------------------------
    assign bus.pend_out  = pend_out_c;
    assign bus.irq_valid = (state == ST_ISSUE);
    assign bus.irq_id    = irq_id_q;
    assign bus.lost      = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_pending_latch.sv
// -----------------------------------------------------------------------------
// tb_irq_pending_latch
//
// Directed bench for irq_pending_latch. An edge-mode instance is driven from
// a table of {inputs, expected outputs} records, followed by hand-written
// sequences for full priority drain and asynchronous reset; a level-mode
// instance covers re-capture of a held request.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_irq_pending_latch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    irq_pending_latch_if bus_e ();
    irq_pending_latch_if bus_l ();

    irq_pending_latch #(.EDGE_MODE(1'b1)) dut_e (
        .clk (clk),
        .rst (rst),
        .bus (bus_e.slave)
    );

    irq_pending_latch #(.EDGE_MODE(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic       lclr;
        logic [7:0] pend;
        logic       valid;
        logic [2:0] id;
        logic [7:0] lost;
    } vec_t;

    localparam int NVEC = 34;
    vec_t tbl [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_e(input string tag, input logic [7:0] pend, input logic valid,
                           input logic [2:0] id, input logic [7:0] lost);
        check({tag, " pend_out"},  bus_e.pend_out,          pend);
        check({tag, " irq_valid"}, 8'(bus_e.irq_valid),     8'(valid));
        check({tag, " irq_id"},    8'(bus_e.irq_id),        8'(id));
        check({tag, " lost"},      bus_e.lost,              lost);
    endtask

    function automatic vec_t mk(input logic [7:0] req, input logic [7:0] mask,
                                input logic ack, input logic lclr,
                                input logic [7:0] pend, input logic valid,
                                input logic [2:0] id, input logic [7:0] lost);
        vec_t v;
        v.req = req;   v.mask = mask; v.ack = ack;     v.lclr = lclr;
        v.pend = pend; v.valid = valid; v.id = id;     v.lost = lost;
        return v;
    endfunction

    initial begin
        logic [7:0] exp_pend;

        //               req    mask   ack  clr   pend   vld  id    lost
        // single request on line 5
        tbl[0]  = mk(8'h20, 8'hFF, 1'b0, 1'b0, 8'h20, 1'b0, 3'd0, 8'h00);
        tbl[1]  = mk(8'h20, 8'hFF, 1'b0, 1'b0, 8'h20, 1'b1, 3'd5, 8'h00);
        tbl[2]  = mk(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 3'd5, 8'h00);
        tbl[3]  = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 3'd5, 8'h00);
        tbl[4]  = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 3'd5, 8'h00);
        // mask 8'h01 over pending 8'h81, then unmask during ISSUE
        tbl[5]  = mk(8'h81, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 3'd5, 8'h00);
        tbl[6]  = mk(8'h81, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 8'h00);
        tbl[7]  = mk(8'h81, 8'hFF, 1'b0, 1'b0, 8'h81, 1'b1, 3'd0, 8'h00);
        tbl[8]  = mk(8'h81, 8'hFF, 1'b0, 1'b0, 8'h81, 1'b1, 3'd0, 8'h00);
        tbl[9]  = mk(8'h00, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 3'd0, 8'h00);
        tbl[10] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b0, 3'd0, 8'h00);
        tbl[11] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b1, 3'd7, 8'h00);
        tbl[12] = mk(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 3'd7, 8'h00);
        tbl[13] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 3'd7, 8'h00);
        // overrun on line 3, then lost_clr
        tbl[14] = mk(8'h08, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b0, 3'd7, 8'h00);
        tbl[15] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 8'h00);
        tbl[16] = mk(8'h08, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 8'h08);
        tbl[17] = mk(8'h00, 8'hFF, 1'b0, 1'b1, 8'h08, 1'b1, 3'd3, 8'h00);
        tbl[18] = mk(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 8'h00);
        tbl[19] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 8'h00);
        // overrun in the same cycle as lost_clr wins
        tbl[20] = mk(8'h08, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b0, 3'd3, 8'h00);
        tbl[21] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 8'h00);
        tbl[22] = mk(8'h08, 8'hFF, 1'b0, 1'b1, 8'h08, 1'b1, 3'd3, 8'h08);
        tbl[23] = mk(8'h00, 8'hFF, 1'b0, 1'b1, 8'h08, 1'b1, 3'd3, 8'h00);
        tbl[24] = mk(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 8'h00);
        tbl[25] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 8'h00);
        // set wins over clear: new edge on line 3 in its ack cycle
        tbl[26] = mk(8'h08, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b0, 3'd3, 8'h00);
        tbl[27] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 8'h00);
        tbl[28] = mk(8'h08, 8'hFF, 1'b1, 1'b0, 8'h08, 1'b0, 3'd3, 8'h00);
        tbl[29] = mk(8'h08, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b0, 3'd3, 8'h00);
        tbl[30] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 8'h00);
        tbl[31] = mk(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 8'h00);
        tbl[32] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 3'd3, 8'h00);
        // ack outside ISSUE is ignored
        tbl[33] = mk(8'h00, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 3'd3, 8'h00);

        bus_e.req_in = 8'h00; bus_e.mask = 8'hFF; bus_e.irq_ack = 1'b0; bus_e.lost_clr = 1'b0;
        bus_l.req_in = 8'h00; bus_l.mask = 8'hFF; bus_l.irq_ack = 1'b0; bus_l.lost_clr = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check_e("reset", 8'h00, 1'b0, 3'd0, 8'h00);
        check("reset lvl pend_out", bus_l.pend_out, 8'h00);
        rst = 1'b0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            bus_e.req_in   = tbl[i].req;
            bus_e.mask     = tbl[i].mask;
            bus_e.irq_ack  = tbl[i].ack;
            bus_e.lost_clr = tbl[i].lclr;
            step();
            check_e($sformatf("vec%0d", i), tbl[i].pend, tbl[i].valid, tbl[i].id, tbl[i].lost);
        end
        bus_e.irq_ack = 1'b0;

        // ---------------- priority drain: all lines, ack held ----------------
        bus_e.req_in = 8'hFF;
        step();
        check_e("prio load", 8'hFF, 1'b0, 3'd3, 8'h00);
        bus_e.irq_ack = 1'b1;
        step();
        check_e("prio issue7", 8'hFF, 1'b1, 3'd7, 8'h00);
        for (int k = 7; k >= 0; k--) begin
            exp_pend = 8'((1 << k) - 1);
            step();
            check_e($sformatf("prio ack%0d", k), exp_pend, 1'b0, 3'(k), 8'h00);
            step();
            check_e($sformatf("prio gap%0d", k), exp_pend, 1'b0, 3'(k), 8'h00);
            if (k > 0) begin
                step();
                check_e($sformatf("prio issue%0d", k - 1), exp_pend, 1'b1, 3'(k - 1), 8'h00);
            end
        end
        bus_e.irq_ack = 1'b0;
        bus_e.req_in  = 8'h00;

        // ---------------- level mode: line 2 held through ack ----------------
        bus_l.req_in = 8'h04;
        step();
        check("lvl cap pend_out", bus_l.pend_out, 8'h04);
        check("lvl cap irq_valid", 8'(bus_l.irq_valid), 8'h00);
        step();
        check("lvl issue irq_valid", 8'(bus_l.irq_valid), 8'h01);
        check("lvl issue irq_id", 8'(bus_l.irq_id), 8'h02);
        for (int r = 0; r < 2; r++) begin
            bus_l.irq_ack = 1'b1;
            step();
            check($sformatf("lvl ack%0d pend_out", r), bus_l.pend_out, 8'h04);
            check($sformatf("lvl ack%0d irq_valid", r), 8'(bus_l.irq_valid), 8'h00);
            check($sformatf("lvl ack%0d lost", r), bus_l.lost, 8'h00);
            bus_l.irq_ack = 1'b0;
            step();
            check($sformatf("lvl gap%0d irq_valid", r), 8'(bus_l.irq_valid), 8'h00);
            step();
            check($sformatf("lvl reissue%0d irq_valid", r), 8'(bus_l.irq_valid), 8'h01);
            check($sformatf("lvl reissue%0d irq_id", r), 8'(bus_l.irq_id), 8'h02);
        end
        bus_l.req_in  = 8'h00;
        bus_l.irq_ack = 1'b1;
        step();
        check("lvl drain pend_out", bus_l.pend_out, 8'h00);
        check("lvl drain lost", bus_l.lost, 8'h00);
        bus_l.irq_ack = 1'b0;

        // ---------------- async reset mid-ISSUE ----------------
        bus_e.req_in = 8'h10;
        step();
        step();
        bus_e.req_in = 8'h00;
        step();
        bus_e.req_in = 8'h10;
        step();
        check_e("pre-rst", 8'h10, 1'b1, 3'd4, 8'h10);
        #3;
        rst = 1'b1;
        #1;
        check_e("async rst", 8'h00, 1'b0, 3'd0, 8'h00);
        #2;
        bus_e.req_in  = 8'h00;
        bus_e.irq_ack = 1'b1;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            check_e($sformatf("stray ack%0d", s), 8'h00, 1'b0, 3'd0, 8'h00);
        end
        bus_e.irq_ack = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
